// File: rtl/mem_access_unit_pkg.sv
// Shared defines for the MEM stage: one-hot aluop codes, bus macros, FSM state and op encodings.
`ifndef MEM_ACCESS_UNIT_DEFS
`define MEM_ACCESS_UNIT_DEFS
`define ALUOP_ONEHOTBUS 7:0
`define REGBUS 31:0
`define ZEROWORD 32'h0000_0000
`endif

package mem_access_unit_pkg;

    localparam logic [`ALUOP_ONEHOTBUS] aluoplb  = 8'b0000_0001;
    localparam logic [`ALUOP_ONEHOTBUS] aluoplbu = 8'b0000_0010;
    localparam logic [`ALUOP_ONEHOTBUS] aluoplh  = 8'b0000_0100;
    localparam logic [`ALUOP_ONEHOTBUS] aluoplhu = 8'b0000_1000;
    localparam logic [`ALUOP_ONEHOTBUS] aluoplw  = 8'b0001_0000;
    localparam logic [`ALUOP_ONEHOTBUS] aluopsb  = 8'b0010_0000;
    localparam logic [`ALUOP_ONEHOTBUS] aluopsh  = 8'b0100_0000;
    localparam logic [`ALUOP_ONEHOTBUS] aluopsw  = 8'b1000_0000;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_DONE   = 2'd2
    } mem_state_t;

    // Compact internal form of the memory op, decoded once from the one-hot bus.
    typedef enum logic [3:0] {
        OP_NONE, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW
    } mem_op_t;

    function automatic logic op_is_load(input mem_op_t op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic op_is_store(input mem_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_misaligned(input mem_op_t op, input logic [1:0] a);
        logic half_op;
        logic word_op;
        half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        word_op = (op == OP_LW) || (op == OP_SW);
        return (half_op && a[0]) || (word_op && (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store lane enables/replication and load byte/halfword extraction with extension.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  a,
    input  logic [31:0] rt,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  rbyte [4];
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    for (genvar gi = 0; gi < 4; gi++) begin : g_rbyte
        assign rbyte[gi] = rdata[8*gi +: 8];
    end

    assign byte_v = rbyte[a];
    assign half_v = a[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        sel   = 4'b1111;
        wdata = `ZEROWORD;
        case (op)
            OP_SB: begin
                sel   = 4'b0001 << a;
                wdata = {4{rt[7:0]}};
            end
            OP_SH: begin
                sel   = a[1] ? 4'b1100 : 4'b0011;
                wdata = {2{rt[15:0]}};
            end
            OP_SW:   wdata = rt;
            default: ;
        endcase
    end

    always_comb begin
        load_data = `ZEROWORD;
        case (op)
            OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_data = {24'h0, byte_v};
            OP_LH:   load_data = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_data = {16'h0, half_v};
            OP_LW:   load_data = rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: req/ack data-memory FSM with stall, timeout and write-back/forward data.
// Optional misalignment exception (align_exc port) is built when MEM_ALIGN_EXC_EN is defined.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ALUOP_W  = 8,
    parameter int WAIT_MAX = 16
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic [`REGBUS]     mem_addr_i,
    input  logic [`REGBUS]     reg2_i,
    input  logic [`REGBUS]     alu_result_i,
    input  logic [4:0]         wd_i,
    input  logic               wreg_i,
    output logic               dm_req,
    output logic               dm_we,
    output logic [3:0]         dm_sel,
    output logic [`REGBUS]     dm_addr,
    output logic [`REGBUS]     dm_wdata,
    input  logic               dm_ack,
    input  logic [`REGBUS]     dm_rdata,
    output logic               stall_req,
    output logic [`REGBUS]     wdata_o,
    output logic [4:0]         wd_o,
    output logic               wreg_o,
    output logic               bus_err
`ifdef MEM_ALIGN_EXC_EN
    ,
    output logic               align_exc
`endif
);

    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    mem_state_t       state_reg;
    mem_op_t          op_in;
    mem_op_t          op_reg;
    mem_op_t          op_cur;
    logic [1:0]       a_reg;
    logic [1:0]       a_cur;
    logic [4:0]       wd_reg;
    logic [`REGBUS]   rdata_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             dm_req_reg;
    logic             dm_we_reg;
    logic [3:0]       dm_sel_reg;
    logic [`REGBUS]   dm_addr_reg;
    logic [`REGBUS]   dm_wdata_reg;
    logic             bus_err_reg;
    logic             is_mem;
    logic             align_fault;
    logic             start;
    logic [3:0]       lane_sel;
    logic [`REGBUS]   lane_wdata;
    logic [`REGBUS]   load_data;

    always_comb begin
        op_in = OP_NONE;
        if      (aluop_i == ALUOP_W'(aluoplb))  op_in = OP_LB;
        else if (aluop_i == ALUOP_W'(aluoplbu)) op_in = OP_LBU;
        else if (aluop_i == ALUOP_W'(aluoplh))  op_in = OP_LH;
        else if (aluop_i == ALUOP_W'(aluoplhu)) op_in = OP_LHU;
        else if (aluop_i == ALUOP_W'(aluoplw))  op_in = OP_LW;
        else if (aluop_i == ALUOP_W'(aluopsb))  op_in = OP_SB;
        else if (aluop_i == ALUOP_W'(aluopsh))  op_in = OP_SH;
        else if (aluop_i == ALUOP_W'(aluopsw))  op_in = OP_SW;
    end

    assign is_mem = (op_in != OP_NONE);

`ifdef MEM_ALIGN_EXC_EN
    assign align_fault = is_mem && op_misaligned(op_in, mem_addr_i[1:0]);
    assign align_exc   = (state_reg == MEM_IDLE) && align_fault;
`else
    assign align_fault = 1'b0;
`endif

    assign start = (state_reg == MEM_IDLE) && is_mem && !align_fault;

    // Lane steering uses the live op in IDLE (to latch store lanes) and the latched op afterwards (load extension).
    assign op_cur = (state_reg == MEM_IDLE) ? op_in : op_reg;
    assign a_cur  = (state_reg == MEM_IDLE) ? mem_addr_i[1:0] : a_reg;

    mem_lane_align u_lane (
        .op        (op_cur),
        .a         (a_cur),
        .rt        (reg2_i),
        .rdata     (dm_rdata),
        .sel       (lane_sel),
        .wdata     (lane_wdata),
        .load_data (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= MEM_IDLE;
            op_reg       <= OP_NONE;
            a_reg        <= 2'b00;
            wd_reg       <= 5'd0;
            rdata_reg    <= `ZEROWORD;
            wait_cnt_reg <= '0;
            dm_req_reg   <= 1'b0;
            dm_we_reg    <= 1'b0;
            dm_sel_reg   <= 4'b0000;
            dm_addr_reg  <= `ZEROWORD;
            dm_wdata_reg <= `ZEROWORD;
            bus_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                MEM_IDLE: begin
                    if (start) begin
                        state_reg    <= MEM_ACCESS;
                        op_reg       <= op_in;
                        a_reg        <= mem_addr_i[1:0];
                        wd_reg       <= wd_i;
                        wait_cnt_reg <= '0;
                        dm_req_reg   <= 1'b1;
                        dm_we_reg    <= op_is_store(op_in);
                        dm_sel_reg   <= lane_sel;
                        dm_addr_reg  <= {mem_addr_i[31:2], 2'b00};
                        dm_wdata_reg <= lane_wdata;
                    end
                end
                MEM_ACCESS: begin
                    wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    if (dm_ack) begin
                        rdata_reg  <= load_data;
                        dm_req_reg <= 1'b0;
                        state_reg  <= MEM_DONE;
                    end else if (wait_cnt_reg == CNT_W'(WAIT_MAX - 1)) begin
                        rdata_reg   <= `ZEROWORD;
                        bus_err_reg <= 1'b1;
                        dm_req_reg  <= 1'b0;
                        state_reg   <= MEM_DONE;
                    end
                end
                MEM_DONE: state_reg <= MEM_IDLE;
                default:  state_reg <= MEM_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_req = 1'b0;
        wdata_o   = `ZEROWORD;
        wd_o      = 5'd0;
        wreg_o    = 1'b0;
        case (state_reg)
            MEM_IDLE: begin
                wd_o = wd_i;
                if (is_mem) begin
                    stall_req = !align_fault;
                end else begin
                    wdata_o = alu_result_i;
                    wreg_o  = wreg_i;
                end
            end
            MEM_ACCESS: begin
                stall_req = 1'b1;
                wd_o      = wd_reg;
            end
            MEM_DONE: begin
                wdata_o = rdata_reg;
                wd_o    = wd_reg;
                wreg_o  = op_is_load(op_reg);
            end
            default: ;
        endcase
    end

    assign dm_req   = dm_req_reg;
    assign dm_we    = dm_we_reg;
    assign dm_sel   = dm_sel_reg;
    assign dm_addr  = dm_addr_reg;
    assign dm_wdata = dm_wdata_reg;
    assign bus_err  = bus_err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed and random load/store transactions against a behavioural model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  aluop;
    logic [31:0] mem_addr;
    logic [31:0] reg2;
    logic [31:0] alu_result;
    logic [4:0]  wd;
    logic        wreg;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_sel;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stall_req;
    logic [31:0] wdata_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic        bus_err;
`ifdef MEM_ALIGN_EXC_EN
    logic        align_exc;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic err_exp = 1'b0;

    mem_access_unit #(.ALUOP_W(8), .WAIT_MAX(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .aluop_i      (aluop),
        .mem_addr_i   (mem_addr),
        .reg2_i       (reg2),
        .alu_result_i (alu_result),
        .wd_i         (wd),
        .wreg_i       (wreg),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_sel       (dm_sel),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_ack       (dm_ack),
        .dm_rdata     (dm_rdata),
        .stall_req    (stall_req),
        .wdata_o      (wdata_o),
        .wd_o         (wd_o),
        .wreg_o       (wreg_o),
        .bus_err      (bus_err)
`ifdef MEM_ALIGN_EXC_EN
        ,
        .align_exc    (align_exc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic is_store(input logic [7:0] op);
        return (op == aluopsb) || (op == aluopsh) || (op == aluopsw);
    endfunction

    function automatic logic [3:0] exp_sel(input logic [7:0] op, input logic [31:0] addr);
        logic [3:0] s;
        s = 4'b1111;
        if (op == aluopsb) begin
            s = 4'b0001;
            s = s << addr[1:0];
        end else if (op == aluopsh) begin
            s = 4'b0011;
            s = s << (2 * addr[1]);
        end
        return s;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [7:0] op, input logic [31:0] rt);
        if (op == aluopsb) return (rt & 32'hFF) * 32'h0101_0101;
        if (op == aluopsh) return (rt & 32'hFFFF) * 32'h0001_0001;
        return rt;
    endfunction

    function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * addr[1:0])) & 32'hFF;
        h = (rd >> (16 * addr[1])) & 32'hFFFF;
        if (op == aluoplb)  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
        if (op == aluoplbu) return b;
        if (op == aluoplh)  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
        if (op == aluoplhu) return h;
        return rd;
    endfunction

    task automatic nop_cycle();
        aluop = 8'h00;
        wreg  = 1'b0;
        @(negedge clk); #1;
    endtask

    // Runs one memory op; ack_cycle = ACCESS cycle that acks (0 = never), lead = idle-stall-free cycles expected first.
    task automatic do_mem(input string name, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] rt, input logic [31:0] rdata, input int ack_cycle,
                          input int lead, input logic [4:0] wdv);
        int zeros;
        int stalls;
        int acc;
        int exp_stall;
        logic finished;
        logic acked;
        logic [31:0] exp_d;
        aluop      = op;
        mem_addr   = addr;
        reg2       = rt;
        wd         = wdv;
        wreg       = 1'b1;
        alu_result = $urandom;
        dm_rdata   = rdata;
        dm_ack     = 1'b0;
        #1;
        zeros = 0; stalls = 0; acc = 0; finished = 1'b0;
        acked = (ack_cycle >= 1) && (ack_cycle <= 16);
        exp_stall = 1 + (acked ? ack_cycle : 16);
        if (!acked) err_exp = 1'b1;
        exp_d = acked ? exp_load(op, addr, rdata) : 32'h0;
        for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
            if (stall_req === 1'b1) begin
                stalls++;
                chk_cnt++;
                if (wreg_o !== 1'b0) $display("FAIL %s_stall_wreg got=%0b exp=0", name, wreg_o);
                else pass_cnt++;
                if (dm_req === 1'b1) begin
                    acc++;
                    chk_cnt++;
                    if ({dm_we, dm_sel, dm_addr} !== {is_store(op), exp_sel(op, addr), addr & 32'hFFFF_FFFC})
                        $display("FAIL %s_bus cyc%0d got we=%0b sel=%04b addr=%08h exp we=%0b sel=%04b addr=%08h",
                                 name, acc, dm_we, dm_sel, dm_addr, is_store(op), exp_sel(op, addr),
                                 addr & 32'hFFFF_FFFC);
                    else pass_cnt++;
                    if (is_store(op)) begin
                        chk_cnt++;
                        if (dm_wdata !== exp_wdata(op, rt))
                            $display("FAIL %s_wdata got=%08h exp=%08h", name, dm_wdata, exp_wdata(op, rt));
                        else pass_cnt++;
                    end
                    dm_ack = (acc == ack_cycle);
                end
            end else if (stalls == 0) begin
                zeros++;
            end else begin
                finished = 1'b1;
                chk_cnt++;
                if (is_store(op)) begin
                    if (wreg_o !== 1'b0) $display("FAIL %s_store_wreg got=%0b exp=0", name, wreg_o);
                    else pass_cnt++;
                end else begin
                    if (wreg_o !== 1'b1 || wdata_o !== exp_d || wd_o !== wdv)
                        $display("FAIL %s_wb got wreg=%0b data=%08h wd=%0d exp wreg=1 data=%08h wd=%0d",
                                 name, wreg_o, wdata_o, wd_o, exp_d, wdv);
                    else pass_cnt++;
                end
                chk_cnt++;
                if (bus_err !== err_exp) $display("FAIL %s_bus_err got=%0b exp=%0b", name, bus_err, err_exp);
                else pass_cnt++;
            end
            if (!finished) begin
                @(negedge clk); #1;
            end
        end
        dm_ack = 1'b0;
        chk_cnt++;
        if (!finished) $display("FAIL %s_timeout got=no_done exp=done", name);
        else pass_cnt++;
        chk_cnt++;
        if (zeros != lead || stalls != exp_stall)
            $display("FAIL %s_stall_len got lead=%0d stall=%0d exp lead=%0d stall=%0d",
                     name, zeros, stalls, lead, exp_stall);
        else pass_cnt++;
        $display("txn %s op=%02h addr=%08h rt=%08h rdata=%08h ack_cycle=%0d stall=%0d", name, op, addr, rt,
                 rdata, ack_cycle, stalls);
    endtask

    task automatic test_reset();
        rst = 1'b1; aluop = 8'h00; mem_addr = 0; reg2 = 0; alu_result = 0; wd = 0; wreg = 0;
        dm_ack = 1'b0; dm_rdata = 0;
        repeat (3) @(negedge clk);
        #1;
        chk_cnt++;
        if ({dm_req, dm_we, dm_sel, dm_addr, dm_wdata, bus_err} !== 71'd0)
            $display("FAIL reset_bus got req=%0b we=%0b sel=%04b addr=%08h wdata=%08h err=%0b exp all 0",
                     dm_req, dm_we, dm_sel, dm_addr, dm_wdata, bus_err);
        else pass_cnt++;
        chk_cnt++;
        if ({stall_req, wreg_o, wdata_o, wd_o} !== 39'd0)
            $display("FAIL reset_comb got stall=%0b wreg=%0b wdata=%08h wd=%0d exp all 0",
                     stall_req, wreg_o, wdata_o, wd_o);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk); #1;
        chk_cnt++;
        if (dm_req !== 1'b0 || stall_req !== 1'b0)
            $display("FAIL reset_release got req=%0b stall=%0b exp 0 0", dm_req, stall_req);
        else pass_cnt++;
        $display("txn reset");
    endtask

    task automatic test_passthrough();
        logic [31:0] v;
        logic [4:0]  r;
        logic        we;
        for (int i = 0; i < 4; i++) begin
            v  = (i == 0) ? 32'd5 : $urandom;
            r  = (i == 0) ? 5'd3 : 5'($urandom_range(0, 31));
            we = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            aluop = 8'h00; alu_result = v; wd = r; wreg = we;
            #1;
            chk_cnt++;
            if (wdata_o !== v || wd_o !== r || wreg_o !== we || stall_req !== 1'b0)
                $display("FAIL pass_%0d got data=%08h wd=%0d wreg=%0b stall=%0b exp data=%08h wd=%0d wreg=%0b stall=0",
                         i, wdata_o, wd_o, wreg_o, stall_req, v, r, we);
            else pass_cnt++;
            $display("txn pass data=%08h wd=%0d wreg=%0b", v, r, we);
            @(negedge clk); #1;
        end
    endtask

    task automatic test_directed();
        do_mem("lw_10",  aluoplw,  32'h10, 32'h0, 32'hDEAD_BEEF, 1, 0, 5'd7);
        nop_cycle();
        do_mem("lb_13",  aluoplb,  32'h13, 32'h0, 32'h80FF_1234, 1, 0, 5'd8);
        nop_cycle();
        do_mem("lbu_13", aluoplbu, 32'h13, 32'h0, 32'h80FF_1234, 1, 0, 5'd9);
        nop_cycle();
        do_mem("sh_22",  aluopsh,  32'h22, 32'h0000_ABCD, 32'h0, 1, 0, 5'd10);
        nop_cycle();
        do_mem("lh_wait3", aluoplh, 32'h46, 32'h0, 32'h9876_5432, 3, 0, 5'd11);
        nop_cycle();
    endtask

    task automatic test_back_to_back();
        do_mem("b2b_lw",  aluoplw,  32'h100, 32'h0, 32'h1234_5678, 1, 0, 5'd1);
        do_mem("b2b_sb",  aluopsb,  32'h101, 32'hA5, 32'h0, 2, 1, 5'd2);
        do_mem("b2b_lhu", aluoplhu, 32'h102, 32'h0, 32'hF00D_8001, 1, 1, 5'd4);
        nop_cycle();
    endtask

    task automatic test_random();
        logic [7:0]  ops [8];
        logic [7:0]  op;
        logic [31:0] addr;
        int lead;
        ops[0] = aluoplb; ops[1] = aluoplbu; ops[2] = aluoplh; ops[3] = aluoplhu;
        ops[4] = aluoplw; ops[5] = aluopsb;  ops[6] = aluopsh; ops[7] = aluopsw;
        for (int i = 0; i < 30; i++) begin
            op   = ops[$urandom_range(0, 7)];
            addr = $urandom;
`ifdef MEM_ALIGN_EXC_EN
            if (op == aluoplh || op == aluoplhu || op == aluopsh) addr[0] = 1'b0;
            if (op == aluoplw || op == aluopsw) addr[1:0] = 2'b00;
`endif
            lead = 1;
            if ($urandom_range(0, 1) == 1) begin
                nop_cycle();
                lead = 0;
            end
            do_mem("rand", op, addr, $urandom, $urandom, $urandom_range(1, 5), lead,
                   5'($urandom_range(1, 31)));
        end
        nop_cycle();
    endtask

    task automatic test_timeout();
        do_mem("timeout_lw", aluoplw, 32'h200, 32'h0, 32'hFFFF_FFFF, 0, 0, 5'd12);
        nop_cycle();
        chk_cnt++;
        if (bus_err !== 1'b1) $display("FAIL timeout_sticky got=%0b exp=1", bus_err);
        else pass_cnt++;
    endtask

    task automatic test_rst_during_access();
        aluop = aluoplw; mem_addr = 32'h40; wd = 5'd6; wreg = 1'b1; dm_rdata = 32'h1111_2222; dm_ack = 1'b0;
        @(negedge clk); #1;
        chk_cnt++;
        if (dm_req !== 1'b1) $display("FAIL rst_acc_req got=%0b exp=1", dm_req);
        else pass_cnt++;
        @(negedge clk); #1;
        rst = 1'b1; aluop = 8'h00; wreg = 1'b0;
        @(negedge clk); #1;
        err_exp = 1'b0;
        chk_cnt++;
        if (dm_req !== 1'b0 || stall_req !== 1'b0 || wreg_o !== 1'b0 || bus_err !== 1'b0)
            $display("FAIL rst_acc_drop got req=%0b stall=%0b wreg=%0b err=%0b exp 0 0 0 0",
                     dm_req, stall_req, wreg_o, bus_err);
        else pass_cnt++;
        rst = 1'b0;
        dm_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk_cnt++;
            if (dm_req !== 1'b0 || wreg_o !== 1'b0 || stall_req !== 1'b0)
                $display("FAIL rst_late_ack_%0d got req=%0b wreg=%0b stall=%0b exp 0 0 0",
                         i, dm_req, wreg_o, stall_req);
            else pass_cnt++;
        end
        dm_ack = 1'b0;
        $display("txn rst_during_access");
    endtask

`ifdef MEM_ALIGN_EXC_EN
    task automatic test_align_exc();
        aluop = aluoplw; mem_addr = 32'h02; wd = 5'd5; wreg = 1'b1;
        #1;
        chk_cnt++;
        if (align_exc !== 1'b1 || stall_req !== 1'b0 || wreg_o !== 1'b0)
            $display("FAIL align_lw got exc=%0b stall=%0b wreg=%0b exp 1 0 0", align_exc, stall_req, wreg_o);
        else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++;
        if (dm_req !== 1'b0) $display("FAIL align_no_req got=%0b exp=0", dm_req);
        else pass_cnt++;
        nop_cycle();
        chk_cnt++;
        if (align_exc !== 1'b0 || dm_req !== 1'b0)
            $display("FAIL align_clear got exc=%0b req=%0b exp 0 0", align_exc, dm_req);
        else pass_cnt++;
        $display("txn align_exc lw addr=00000002");
        do_mem("align_lh_ok", aluoplh, 32'h02, 32'h0, 32'h8001_0000, 1, 0, 5'd13);
        nop_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_passthrough();
        test_directed();
        test_back_to_back();
        test_random();
        test_timeout();
        test_rst_during_access();
`ifdef MEM_ALIGN_EXC_EN
        test_align_exc();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store unit of the five-stage pipelined MIPS CPU. It consumes the EX-stage memory outputs (op, effective address, store data) and drives a req/ack data-memory port. It generates byte/halfword lane selects and load extension, stalls the pipeline while the access is outstanding, and produces write-back and forwarding data for the register file.

Parameters:
ALUOP_W, 8, width of the one-hot aluop bus (matches `aluop_onehotbus in the shared defines)
WAIT_MAX, 16, maximum cycles to wait for dm_ack before a bus timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
aluop_i  in  ALUOP_W  one-hot op from EX; the load/store codes are lb, lbu, lh, lhu, lw, sb, sh, sw
mem_addr_i  in  32  effective address (base + sign-extended offset)
reg2_i  in  32  store data (rt)
alu_result_i  in  32  EX result for non-memory ops
wd_i  in  5  destination register
wreg_i  in  1  register write enable
dm_req  out  1  data-memory request
dm_we  out  1  1 = store, 0 = load
dm_sel  out  4  byte-lane enables; bit0 = byte 0, little-endian lanes
dm_addr  out  32  word-aligned address, {addr[31:2], 2'b00}
dm_wdata  out  32  store data replicated to lanes
dm_ack  in  1  memory completes the access this cycle
dm_rdata  in  32  read data, valid when dm_ack = 1
stall_req  out  1  freeze IF/ID/EX and the EX/MEM register
wdata_o  out  32  write-back data
wd_o  out  5  write-back register
wreg_o  out  1  write-back enable
bus_err  out  1  sticky timeout flag, cleared only by rst

Behaviour:
- Reset (synchronous, active-high, registered at rising clk): state IDLE; dm_req=0, dm_we=0, dm_sel=0, dm_addr=0, dm_wdata=0, bus_err=0, wait counter=0. Combinational outputs are 0 while state is IDLE with no memory op.
- States: IDLE, ACCESS, DONE.
- Non-memory op in IDLE:
  - Zero-latency pass-through: wdata_o = alu_result_i, wd_o = wd_i, wreg_o = wreg_i.
  - stall_req = 0.
- Memory op in IDLE:
  - stall_req = 1 combinationally in the same cycle.
  - wreg_o = 0.
  - At the next edge, move to ACCESS and register dm_addr, dm_we, dm_sel, dm_wdata, op, and wd.
- ACCESS:
  - dm_req = 1; stall_req = 1; all dm_* outputs are held stable.
  - Counter increments each cycle.
  - dm_ack = 1: capture the extended rdata and go to DONE.
  - Counter reaches WAIT_MAX-1 with no ack: set bus_err, capture data 0, go to DONE.
- DONE (one cycle):
  - dm_req = 0; stall_req = 0.
  - Loads: wdata_o = captured data, wd_o = latched wd, wreg_o = 1.
  - Stores: wreg_o = 0.
  - Next state is IDLE.
  - The EX/MEM register advances this cycle, so back-to-back memory ops re-enter ACCESS after one IDLE cycle.
- Minimum memory-op stall is 2 cycles (ack in the first ACCESS cycle).
- Lane selection, a = addr[1:0]:
  - sb: sel = 1<<a; wdata = {4{rt[7:0]}}.
  - sh: sel = a[1] ? 4'b1100 : 4'b0011; wdata = {2{rt[15:0]}}.
  - sw: sel = 4'b1111.
  - Loads: sel = 4'b1111.
- Load extension: select byte a or halfword a[1] from dm_rdata. lb and lh sign-extend; lbu and lhu zero-extend; lw takes the full word.
- Misaligned addresses without the optional feature: the address is truncated to the lane rules above; no exception.
- dm_ack outside ACCESS is ignored.
- rst asserted during ACCESS: dm_req drops at that edge and the access is abandoned; no write-back.
- Forwarding: wdata_o, wd_o, and wreg_o also feed the ID-stage forwarding mux. They are valid only when wreg_o = 1.

Optional Feature:
MEM_ALIGN_EXC_EN
- Defined:
  - Adds output align_exc (1 bit).
  - lh/lhu/sh with addr[0] = 1, or lw/sw with addr[1:0] != 0, never enters ACCESS.
  - In that case align_exc pulses for one cycle in IDLE, wreg_o = 0, and stall_req = 0.
- Undefined: the port is absent and misaligned accesses are truncated as described above.

Decomposition:
- Shared defines package holds:
  - one-hot codes aluoplb, aluoplbu, aluoplh, aluoplhu, aluoplw, aluopsb, aluopsh, aluopsw;
  - `aluop_onehotbus, `regbus, `zeroword;
  - state encodings MEM_IDLE, MEM_ACCESS, MEM_DONE.
- One natural combinational sub-module, mem_lane_align: produces dm_sel and dm_wdata from op, a, and rt, and load extension from op, a, and rdata. The FSM stays in mem_access_unit.

Test Plan:
- lw at 0x10, memory acks on the first ACCESS cycle with 0xDEADBEEF: stall_req high for 2 cycles; DONE gives wdata_o = 0xDEADBEEF with wreg_o = 1.
- lb at 0x13 with rdata 0x80FF_1234: wdata_o = 0xFFFFFF80. lbu at the same address gives 0x00000080.
- sh at 0x22 with rt 0x0000ABCD: dm_sel = 4'b1100, dm_wdata = 0xABCDABCD, dm_we = 1, dm_addr = 0x20, wreg_o = 0.
- Ack withheld for 3 cycles: dm_* outputs stay stable throughout and stall_req = 1 for 4 cycles. With no ack at all, bus_err sets after 16 ACCESS cycles and wdata_o = 0.
- rst during ACCESS: dm_req = 0 after that edge; no wreg_o pulse; a later dm_ack is ignored.
- add result 0x5 to r3: same-cycle pass-through (wdata_o = 5, wd_o = 3, wreg_o = 1) with no stall. With MEM_ALIGN_EXC_EN, lw at 0x02 gives an align_exc pulse and no dm_req.
